// File: rtl/conv_stream_engine.sv
// Streaming valid-mode 2-D correlation engine: loads an input matrix and a kernel byte by byte,
// then emits one MAC-accumulated result per output position over a valid/ready handshake.
module conv_stream_engine #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned MAX_DIM = 6,
    parameter int unsigned DIM_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIM_W-1:0]  inRow,
    input  logic [DIM_W-1:0]  inCol,
    input  logic [DIM_W-1:0]  kerRow,
    input  logic [DIM_W-1:0]  kerCol,
    input  logic              inValid,
    input  logic [DATA_W-1:0] inMatrix,
    output logic              inReady,
    input  logic              kerValid,
    input  logic [DATA_W-1:0] kernel,
    output logic              kerReady,
    output logic              outValid,
    input  logic              outReady,
    output logic [OUT_W-1:0]  outMatrix,
    output logic              outLast,
    output logic              dimErr
);

    localparam int unsigned IDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam logic [DIM_W-1:0] MAX_IDX = DIM_W'(MAX_DIM - 1);

    typedef enum logic [1:0] {
        LOAD_IN,
        LOAD_KER,
        COMPUTE,
        EMIT
    } state_t;

    state_t state;

    logic [DIM_W-1:0] in_row, in_col, ker_row, ker_col;
    logic [DIM_W-1:0] r, c;
    logic [DIM_W-1:0] i, j;
    logic [DIM_W-1:0] k, l;
    logic [OUT_W-1:0] acc;

    logic             in_ready, ker_ready, out_valid, out_last, dim_err;
    logic [OUT_W-1:0] out_matrix;

    logic [DATA_W-1:0] in_mem  [MAX_DIM][MAX_DIM];
    logic [DATA_W-1:0] ker_mem [MAX_DIM][MAX_DIM];

    logic             first_beat, dims_bad, in_we, ker_we;
    logic [DIM_W-1:0] eff_in_row, eff_in_col;
    logic             in_last_col, in_last, ker_last_col, ker_last;
    logic [IDX_W-1:0] row_idx, col_idx;
    logic [OUT_W-1:0] prod, mac;
    logic             mac_last, final_pos, last_out_col;

    // The first beat is checked against the live dim ports; later beats use the latched dims.
    always_comb begin
        first_beat   = (r == '0) && (c == '0);
        dims_bad     = (inRow > MAX_IDX) || (inCol > MAX_IDX) ||
                       (kerRow > inRow) || (kerCol > inCol);
        in_we        = (state == LOAD_IN) && inValid && !(first_beat && dims_bad);
        ker_we       = (state == LOAD_KER) && kerValid;
        eff_in_row   = first_beat ? inRow : in_row;
        eff_in_col   = first_beat ? inCol : in_col;
        in_last_col  = (c == eff_in_col);
        in_last      = in_last_col && (r == eff_in_row);
        ker_last_col = (c == ker_col);
        ker_last     = ker_last_col && (r == ker_row);

        row_idx      = i[IDX_W-1:0] + k[IDX_W-1:0];
        col_idx      = j[IDX_W-1:0] + l[IDX_W-1:0];
        prod         = OUT_W'(in_mem[row_idx][col_idx]) * OUT_W'(ker_mem[k[IDX_W-1:0]][l[IDX_W-1:0]]);
        mac          = acc + prod;
        mac_last     = (l == ker_col) && (k == ker_row);
        last_out_col = (j == in_col - ker_col);
        final_pos    = (i == in_row - ker_row) && last_out_col;
    end

    always_ff @(posedge clk) begin
        if (in_we) begin
            in_mem[r[IDX_W-1:0]][c[IDX_W-1:0]] <= inMatrix;
        end
        if (ker_we) begin
            ker_mem[r[IDX_W-1:0]][c[IDX_W-1:0]] <= kernel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD_IN;
            in_row     <= '0;
            in_col     <= '0;
            ker_row    <= '0;
            ker_col    <= '0;
            r          <= '0;
            c          <= '0;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            l          <= '0;
            acc        <= '0;
            in_ready   <= 1'b1;
            ker_ready  <= 1'b0;
            out_valid  <= 1'b0;
            out_matrix <= '0;
            out_last   <= 1'b0;
            dim_err    <= 1'b0;
        end else begin
            case (state)
                LOAD_IN: begin
                    if (inValid && first_beat) begin
                        dim_err <= dims_bad;
                        if (!dims_bad) begin
                            in_row  <= inRow;
                            in_col  <= inCol;
                            ker_row <= kerRow;
                            ker_col <= kerCol;
                        end
                    end
                    if (in_we) begin
                        if (in_last) begin
                            r         <= '0;
                            c         <= '0;
                            state     <= LOAD_KER;
                            in_ready  <= 1'b0;
                            ker_ready <= 1'b1;
                        end else if (in_last_col) begin
                            c <= '0;
                            r <= r + DIM_W'(1);
                        end else begin
                            c <= c + DIM_W'(1);
                        end
                    end
                end

                LOAD_KER: begin
                    if (ker_we) begin
                        if (ker_last) begin
                            r         <= '0;
                            c         <= '0;
                            i         <= '0;
                            j         <= '0;
                            k         <= '0;
                            l         <= '0;
                            acc       <= '0;
                            state     <= COMPUTE;
                            ker_ready <= 1'b0;
                        end else if (ker_last_col) begin
                            c <= '0;
                            r <= r + DIM_W'(1);
                        end else begin
                            c <= c + DIM_W'(1);
                        end
                    end
                end

                COMPUTE: begin
                    if (mac_last) begin
                        acc        <= '0;
                        k          <= '0;
                        l          <= '0;
                        out_matrix <= mac;
                        out_valid  <= 1'b1;
                        out_last   <= final_pos;
                        state      <= EMIT;
                    end else begin
                        acc <= mac;
                        if (l == ker_col) begin
                            l <= '0;
                            k <= k + DIM_W'(1);
                        end else begin
                            l <= l + DIM_W'(1);
                        end
                    end
                end

                EMIT: begin
                    if (outReady) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            i        <= '0;
                            j        <= '0;
                            in_ready <= 1'b1;
                            state    <= LOAD_IN;
                        end else begin
                            state <= COMPUTE;
                            if (last_out_col) begin
                                j <= '0;
                                i <= i + DIM_W'(1);
                            end else begin
                                j <= j + DIM_W'(1);
                            end
                        end
                    end
                end

                default: state <= LOAD_IN;
            endcase
        end
    end

    assign inReady   = in_ready;
    assign kerReady  = ker_ready;
    assign outValid  = out_valid;
    assign outMatrix = out_matrix;
    assign outLast   = out_last;
    assign dimErr    = dim_err;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine: a reference correlation model queues expected results
// as each frame is driven, and a consumer process pops and compares them as the DUT emits.
module tb_conv_stream_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  inRow = '0, inCol = '0, kerRow = '0, kerCol = '0;
    logic        inValid = 1'b0, kerValid = 1'b0, outReady = 1'b0;
    logic [7:0]  inMatrix = '0, kernel = '0;
    logic        inReady, kerReady, outValid, outLast, dimErr;
    logic [15:0] outMatrix;

    conv_stream_engine #(.DATA_W(8), .OUT_W(16), .MAX_DIM(6), .DIM_W(4)) dut (
        .clk(clk), .rst(rst),
        .inRow(inRow), .inCol(inCol), .kerRow(kerRow), .kerCol(kerCol),
        .inValid(inValid), .inMatrix(inMatrix), .inReady(inReady),
        .kerValid(kerValid), .kernel(kernel), .kerReady(kerReady),
        .outValid(outValid), .outReady(outReady), .outMatrix(outMatrix),
        .outLast(outLast), .dimErr(dimErr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int results_seen = 0;
    int in_m [6][6];
    int ker_m [6][6];
    logic [15:0] exp_val [$];
    logic        exp_last [$];
    bit rand_ready = 1'b0;
    int hold_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference correlation, 16-bit wrapping accumulation.
    task automatic push_expected(input int ir, input int ic, input int kr, input int kc);
        for (int oi = 0; oi <= ir - kr; oi++) begin
            for (int oj = 0; oj <= ic - kc; oj++) begin
                logic [15:0] s;
                s = '0;
                for (int a = 0; a <= kr; a++)
                    for (int b = 0; b <= kc; b++)
                        s = s + 16'(in_m[oi+a][oj+b] * ker_m[a][b]);
                exp_val.push_back(s);
                exp_last.push_back((oi == ir - kr) && (oj == ic - kc));
            end
        end
    endtask

    task automatic drive_beat(input bit is_ker, input logic [7:0] v, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        if (is_ker) begin kerValid = 1'b1; kernel = v; end
        else begin inValid = 1'b1; inMatrix = v; end
        n = 0;
        while (!(is_ker ? kerReady : inReady) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check(is_ker ? "ker_beat_timeout" : "in_beat_timeout", 0, 1);
        @(negedge clk);
        inValid = 1'b0;
        kerValid = 1'b0;
    endtask

    task automatic send_frame(input int ir, input int ic, input int kr, input int kc,
                              input bit gaps, input bit scramble);
        push_expected(ir, ic, kr, kc);
        inRow = 4'(ir); inCol = 4'(ic); kerRow = 4'(kr); kerCol = 4'(kc);
        for (int a = 0; a <= ir; a++)
            for (int b = 0; b <= ic; b++) begin
                drive_beat(1'b0, 8'(in_m[a][b]), gaps);
                if (scramble) begin
                    inRow = 4'($urandom_range(0, 15)); inCol = 4'($urandom_range(0, 15));
                    kerRow = 4'($urandom_range(0, 15)); kerCol = 4'($urandom_range(0, 15));
                end
            end
        for (int a = 0; a <= kr; a++)
            for (int b = 0; b <= kc; b++)
                drive_beat(1'b1, 8'(ker_m[a][b]), gaps);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_val.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_val.size(), 0);
        exp_val.delete();
        exp_last.delete();
        @(negedge clk);
        check({tag, "_idle_outValid"}, outValid, 0);
        check({tag, "_idle_inReady"}, inReady, 1);
    endtask

    task automatic clear_mats();
        for (int a = 0; a < 6; a++)
            for (int b = 0; b < 6; b++) begin
                in_m[a][b] = 0;
                ker_m[a][b] = 0;
            end
    endtask

    task automatic load_test1();
        clear_mats();
        in_m[0][0] = 1; in_m[0][1] = 0; in_m[0][2] = 2; in_m[0][3] = 3; in_m[0][4] = 4;
        for (int a = 1; a < 5; a++)
            for (int b = 0; b < 5; b++)
                in_m[a][b] = 5 * a + b;
        ker_m[0][0] = 1; ker_m[0][2] = 1; ker_m[1][1] = 1; ker_m[2][0] = 1; ker_m[2][2] = 1;
    endtask

    task automatic load_test2();
        clear_mats();
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                in_m[a][b] = 3 * a + b + 1;
        ker_m[0][0] = 1;
    endtask

    // Consumer: picks outReady at each falling edge; a handshake then happens on the next rising edge.
    initial begin
        bit pending;
        logic [15:0] held_val;
        logic held_last;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0;
                outReady = 1'b0;
            end else begin
                if (hold_cycles > 0 && outValid) begin
                    outReady = 1'b0;
                    hold_cycles--;
                end else begin
                    outReady = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (pending) begin
                    check("stall_outValid", outValid, 1);
                    check("stall_outMatrix", outMatrix, held_val);
                    check("stall_outLast", outLast, held_last);
                end
                pending = 1'b0;
                if (outValid) begin
                    if (outReady) begin
                        if (exp_val.size() == 0) begin
                            check("unexpected_output", outMatrix, 16'hxxxx);
                        end else begin
                            check("result", outMatrix, exp_val.pop_front());
                            check("result_last", outLast, exp_last.pop_front());
                            results_seen++;
                        end
                    end else begin
                        pending = 1'b1;
                        held_val = outMatrix;
                        held_last = outLast;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_inReady", inReady, 1);
        check("rst_kerReady", kerReady, 0);
        check("rst_outValid", outValid, 0);
        check("rst_outMatrix", outMatrix, 0);
        check("rst_outLast", outLast, 0);
        check("rst_dimErr", dimErr, 0);

        // 1: 6x6 input, 4x4 sparse kernel
        load_test1();
        base = results_seen;
        send_frame(5, 5, 3, 3, 1'b0, 1'b0);
        check("t1_kerReady_after_load", kerReady, 0);
        wait_drain("t1_drain");
        check("t1_count", results_seen - base, 9);

        // 2: 1x1 identity kernel
        load_test2();
        base = results_seen;
        send_frame(2, 2, 0, 0, 1'b0, 1'b0);
        wait_drain("t2_drain");
        check("t2_count", results_seen - base, 9);

        // 3: full-size all-255 frame, wrapped single result
        for (int a = 0; a < 6; a++)
            for (int b = 0; b < 6; b++) begin
                in_m[a][b] = 255;
                ker_m[a][b] = 255;
            end
        base = results_seen;
        send_frame(5, 5, 5, 5, 1'b0, 1'b0);
        wait_drain("t3_drain");
        check("t3_count", results_seen - base, 1);

        // 4: bad dims drop the beat, then a valid frame clears dimErr
        inRow = 4'd2; inCol = 4'd2; kerRow = 4'd4; kerCol = 4'd0;
        drive_beat(1'b0, 8'd7, 1'b0);
        check("t4_dimErr_set", dimErr, 1);
        check("t4_inReady", inReady, 1);
        drive_beat(1'b0, 8'd9, 1'b0);
        check("t4_dimErr_again", dimErr, 1);
        repeat (4) @(negedge clk);
        check("t4_kerReady", kerReady, 0);
        check("t4_outValid", outValid, 0);
        clear_mats();
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 5; b++)
                in_m[a][b] = $urandom_range(0, 255);
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 3; b++)
                ker_m[a][b] = $urandom_range(0, 255);
        send_frame(3, 4, 1, 2, 1'b0, 1'b0);
        check("t4_dimErr_cleared", dimErr, 0);
        wait_drain("t4_drain");

        // 5: back-pressure, random gaps, dim ports scrambled mid-frame
        load_test1();
        hold_cycles = 10;
        rand_ready = 1'b1;
        base = results_seen;
        send_frame(5, 5, 3, 3, 1'b1, 1'b1);
        wait_drain("t5_drain");
        check("t5_count", results_seen - base, 9);
        rand_ready = 1'b0;

        // 6: async reset during COMPUTE, then a fresh frame
        for (int a = 0; a < 6; a++)
            for (int b = 0; b < 6; b++) begin
                in_m[a][b] = a + b;
                ker_m[a][b] = 1;
            end
        send_frame(5, 5, 5, 5, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        exp_val.delete();
        exp_last.delete();
        check("t6_rst_outValid", outValid, 0);
        check("t6_rst_inReady", inReady, 1);
        check("t6_rst_kerReady", kerReady, 0);
        rst = 1'b0;
        @(negedge clk);
        load_test2();
        base = results_seen;
        send_frame(2, 2, 0, 0, 1'b1, 1'b0);
        wait_drain("t6_drain");
        check("t6_count", results_seen - base, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
